register_file_wb: RTL and testbench
===================================

// Module: register_file_wb
// PURPOSE
//   Write-back end of the single-cycle datapath: 32 x 32-bit MIPS register file.
//   Takes the 5-bit destination index chosen by the rt/rd write-register mux and
//   decodes it to one-hot write enables (the inverse, demux direction).
//   Two asynchronous read ports feed the ALU operands; the write port is clocked.
//   Provides $zero hard-wiring and optional same-cycle write-to-read bypass.
// PARAMETERS
//   DATA_W   32  register / data width
//   ADDR_W   5   register index width; depth = 2**ADDR_W
//   BYPASS   1   1: a read of the register being written returns write_data; 0: returns old value
// PORTS
//   clk          in   1        rising-edge clock
//   reset        in   1        synchronous, active-high
//   read_reg1    in   ADDR_W   rs index
//   read_reg2    in   ADDR_W   rt index
//   write_reg    in   ADDR_W   destination index (output of write-register mux)
//   write_data   in   DATA_W   write-back value (ALU result / memory data mux)
//   reg_write    in   1        write enable from control unit
//   read_data1   out  DATA_W   contents of read_reg1
//   read_data2   out  DATA_W   contents of read_reg2
// BEHAVIOUR
//   - Reset: on the rising edge with reset=1, all 2**ADDR_W registers <= 0.
//     While reset=1, read_data1/read_data2 are forced to 0 (combinational).
//   - Write: on the rising edge with reset=0 and reg_write=1, regs[write_reg] <= write_data.
//     Decoder output = one-hot(write_reg) & {reg_write}; exactly one register updates.
//   - $zero: a write to index 0 is discarded; regs[0] stays 0 permanently.
//     A read of index 0 returns 0, including when BYPASS=1 and write_reg=0.
//   - Read: combinational, zero-cycle latency; read_dataN = regs[read_regN].
//   - Same-cycle read/write of the same nonzero index with reg_write=1:
//     BYPASS=1 -> read_dataN = write_data in that cycle; BYPASS=0 -> old value,
//     new value visible after the edge.
//   - Both ports may address the same register; both return identical data.
//   - reset and reg_write asserted together: reset wins; no write occurs.
//   - Reset asserted mid-program: the next edge clears every register; first
//     write is accepted on the first edge with reset=0.
//   - reg_write=0: no register changes regardless of write_reg/write_data.
//   - X/undefined write_reg with reg_write=0 is harmless (decoder gated).
// STRUCTURE
//   - cpu_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0, NUM_REGS=32;
//     shared with the control unit and write-register mux.
//   - Sub-module decoder_5to32: in [4:0] idx, en -> out [31:0] one-hot write enables.
//   - Top: register array, per-register enable flops, two read mux trees + bypass compare.
// TESTING
//   1. Pulse reset 1 cycle, then read all 32 indices -> every read_data = 0.
//   2. reg_write=1, write_reg=13, write_data=32'hDEADBEEF; next cycle read_reg1=13 -> 32'hDEADBEEF;
//      read_reg2=8 -> 0 (no neighbour corruption).
//   3. reg_write=1, write_reg=0, write_data=32'hFFFFFFFF; read_reg1=0 -> 0 same cycle and after.
//   4. BYPASS=1: write_reg=8, write_data=32'h1234, read_reg2=8 same cycle -> 32'h1234 before
//      the edge; BYPASS=0 build -> old value, then 32'h1234 after the edge.
//   5. reg 13 = 32'h5; assert reset with reg_write=1, write_reg=13, write_data=32'h9 -> after
//      the edge regs[13]=0, no write.
//   6. reg_write=0, write_reg=13, write_data=32'hAAAA -> regs[13] unchanged; random
//      write/read sequence checked against a reference array model for 1000 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Datapath-wide register-file constants, shared by the control unit,
// the write-register mux and the register file.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REGS   = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage : cpu_pkg

// File: rtl/decoder_5to32.sv
// Register-index to one-hot write-enable decoder (demux direction of the
// write-register mux); the enable gates every output so an unknown index is inert.
module decoder_5to32
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]      idx,
    input  logic                   en,
    output logic [2**ADDR_W-1:0]   out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[idx] = 1'b1;
        end
    end

endmodule : decoder_5to32

// File: rtl/register_file_wb.sv
// Write-back register file: clocked one-hot write port, two asynchronous
// read ports, hard-wired $zero and optional same-cycle write-to-read bypass.
module register_file_wb
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  w_we;
    logic              w_wr_en;

    // Reset has priority, so the decoder is gated off while it is asserted.
    assign w_wr_en = reg_write & ~reset;

    decoder_5to32 #(
        .ADDR_W (ADDR_W)
    ) u_dec (
        .idx (write_reg),
        .en  (w_wr_en),
        .out (w_we)
    );

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reset || i == 0) begin
                r_regs[i] <= '0;
            end else if (w_we[i]) begin
                r_regs[i] <= write_data;
            end
        end
    end

    always_comb begin
        read_data1 = '0;
        if (!reset && read_reg1 != ZERO_IDX) begin
            if (BYPASS && reg_write && write_reg == read_reg1) begin
                read_data1 = write_data;
            end else begin
                read_data1 = r_regs[read_reg1];
            end
        end
    end

    always_comb begin
        read_data2 = '0;
        if (!reset && read_reg2 != ZERO_IDX) begin
            if (BYPASS && reg_write && write_reg == read_reg2) begin
                read_data2 = write_data;
            end else begin
                read_data2 = r_regs[read_reg2];
            end
        end
    end

endmodule : register_file_wb

// File: tb/tb_register_file_wb.sv
// Directed and random checks of register_file_wb, bypass and non-bypass
// builds side by side against an array reference model.
module tb_register_file_wb;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [31:0] ref_regs [32];

    always #5 clk = ~clk;

    register_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_b), .read_data2(rd2_b)
    );

    register_file_wb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) dut_nob (
        .clk(clk), .reset(reset), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .read_data1(rd1_n), .read_data2(rd2_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected read value from the spec rules applied to the current inputs.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (reset || a == 5'd0) return 32'd0;
        if (byp && reg_write && write_reg == a) return write_data;
        return ref_regs[a];
    endfunction

    // Apply one cycle of inputs, check reads mid-cycle, then commit the edge to the model.
    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input string tag);
        reset      = rst;
        reg_write  = we;
        write_reg  = wa;
        write_data = wd;
        read_reg1  = r1;
        read_reg2  = r2;
        #2;
        chk({tag, ".byp.rd1"}, rd1_b, exp_rd(r1, 1'b1));
        chk({tag, ".byp.rd2"}, rd2_b, exp_rd(r2, 1'b1));
        chk({tag, ".nob.rd1"}, rd1_n, exp_rd(r1, 1'b0));
        chk({tag, ".nob.rd2"}, rd2_n, exp_rd(r2, 1'b0));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            ref_regs[wa] = wd;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  ra, r1, r2;
        logic [31:0] rd;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;

        // 1: reset, then every index reads zero
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "rst");
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i);
            drive(1'b0, 1'b0, 5'd0, 32'd0, ra, ~ra, "rst_rd");
        end

        // 2: write 13, no neighbour corruption
        drive(1'b0, 1'b1, 5'd13, 32'hDEADBEEF, 5'd13, 5'd8, "wr13");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd8, "rd13");
        chk("rd13.direct", rd1_n, 32'hDEADBEEF);

        // 3: $zero discards writes, including under bypass
        drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "wr0");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "rd0");

        // 4: same-cycle read of the register being written
        drive(1'b0, 1'b1, 5'd8, 32'h1234, 5'd0, 5'd8, "byp8");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd8, "rd8");

        // 5: reset beats reg_write
        drive(1'b0, 1'b1, 5'd13, 32'h5, 5'd13, 5'd13, "wr13_5");
        drive(1'b1, 1'b1, 5'd13, 32'h9, 5'd13, 5'd13, "rst_we");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd8, "rd13_rst");

        // 6: reg_write=0 leaves state untouched, even with an unknown index
        drive(1'b0, 1'b1, 5'd13, 32'h7, 5'd1, 5'd2, "wr13_7");
        drive(1'b0, 1'b0, 5'd13, 32'hAAAA, 5'd13, 5'd13, "nowe");
        drive(1'b0, 1'b0, 5'bx, 32'hAAAA, 5'd13, 5'd8, "nowe_x");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd13, 5'd8, "rd13_7");

        for (int n = 0; n < 1000; n++) begin
            ra = 5'($urandom_range(0, 31));
            rd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 1),
                  ra, rd, r1, r2, "rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_register_file_wb
